regsel_arbiter: RTL and testbench

//  Shares the single 32x8 address-register read mux between NUM_REQ requesters
//  (e.g. fetch unit, load/store unit).

---
 rtl/regsel_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/regsel_arbiter.sv | 127 ++++++++++++
 tb/tb_regsel_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regsel_pkg.sv
// ----------------------------------------------------------------------------
// regsel_pkg
// Shared types and defaults for the address-register read arbiter.
//   state_t      : arbiter FSM states (IDLE -> ISSUE -> RESP -> IDLE)
//   SEL_W_DEF    : default register-select width (32 address registers)
//   DATA_W_DEF   : default width of one address register
//   NUM_REQ_MAX  : largest supported number of requesters
// ----------------------------------------------------------------------------
package regsel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int SEL_W_DEF   = 5;
    localparam int DATA_W_DEF  = 8;
    localparam int NUM_REQ_MAX = 4;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick among NUM_REQ request lines.
// The search starts at index ptr and walks upward with wrap-around; the
// first asserted request wins.
//   req  in  NUM_REQ  request lines
//   ptr  in  PTR_W    index with highest priority this round (< NUM_REQ)
//   gnt  out NUM_REQ  one-hot winner, all zero when no request is asserted
// ----------------------------------------------------------------------------
module rr_arbiter
    import regsel_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
        $error("rr_arbiter: NUM_REQ out of supported range");
    end

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the loop can leave a value unassigned and infer a latch.
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr + i never reaches 2*NUM_REQ, so one conditional subtract
            // is enough for the modulo.
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regsel_arbiter.sv
// ----------------------------------------------------------------------------
// regsel_arbiter
// Shares the single address-register read mux between NUM_REQ requesters.
// One request is granted at a time (round-robin), its select is driven to the
// mux, the returned byte is registered and handed back with valid/ready.
//   clk        in   single clock, all state on rising edge
//   rst        in   synchronous, active-high reset
//   req_valid  in   per-requester read request
//   req_sel    in   per-requester register index, req i at [i*SEL_W +: SEL_W]
//   req_ready  out  one-hot accept (only in IDLE, never during reset)
//   rsp_valid  out  one-hot response valid for the granted requester
//   rsp_ready  in   per-requester response accept (only the granted bit counts)
//   rsp_data   out  registered byte returned to the granted requester
//   addsel     out  select to the address mux
//   addout     in   byte from the address mux
// ----------------------------------------------------------------------------
module regsel_arbiter
    import regsel_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*SEL_W-1:0] req_sel,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [SEL_W-1:0]         addsel,
    input  logic [DATA_W-1:0]        addout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t             state_q,    state_d;
    logic [PTR_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [PTR_W-1:0]   grant_q,    grant_d;
    logic [SEL_W-1:0]   addsel_q,   addsel_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   win_idx;
    logic [SEL_W-1:0]   win_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // Encode the one-hot winner and pick its select with constant part-selects.
    always_comb begin
        win_idx = '0;
        win_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx = PTR_W'(i);
                win_sel = req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        addsel_d   = addsel_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        rsp_valid  = '0;

        unique case (state_q)
            IDLE: begin
                // Accept is advertised only outside reset.
                req_ready = rst ? '0 : gnt;
                if (|req_valid) begin
                    grant_d  = win_idx;
                    addsel_d = win_sel;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // addsel was registered last cycle, so addout is settled now.
                rsp_data_d = addout;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    rr_ptr_d = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            addsel_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            addsel_q   <= addsel_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign addsel   = addsel_q;
    assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_regsel_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regsel_arbiter
// Self-checking bench for regsel_arbiter with two requesters. The address mux
// is modelled as byte k = 8'h10 + k. Expected grants come from a round-robin
// pointer tracked at transaction level; expected timing is the fixed
// accept -> select -> response sequence.
// ----------------------------------------------------------------------------
module tb_regsel_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [9:0]  req_sel;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_data;
    logic [4:0]  addsel;
    logic [7:0]  addout;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    regsel_arbiter #(
        .NUM_REQ (2),
        .SEL_W   (5),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .addsel    (addsel),
        .addout    (addout)
    );

    always #5 clk = ~clk;

    // Address-register mux model.
    assign addout = 8'h10 + {3'b000, addsel};

    function automatic int winner(input logic [1:0] v, input int p);
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = (p + k) % 2;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] mux_byte(input logic [4:0] k);
        return 8'h10 + {3'b000, k};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        req_sel   = 10'h3FF;
        rsp_ready = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready_pre got=%b want=%b", req_ready, 2'b00);
        end
        step();
        step();
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got=%b want=%b", req_ready, 2'b00);
        end
        total++;
        if (rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL reset_rsp_valid got=%b want=%b", rsp_valid, 2'b00);
        end
        total++;
        if (addsel !== 5'd0) begin
            bad++;
            $display("FAIL reset_addsel got=%0d want=0", addsel);
        end
        total++;
        if (rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_rsp_data got=%h want=00", rsp_data);
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        ptr_m     = 0;
        step();
    endtask

    // One full transaction starting from IDLE. 'hold' keeps the winner's
    // valid asserted afterwards; otherwise it drops after accept. 'stall'
    // cycles of RESP see rsp_ready only on the non-granted bit.
    task automatic serve_one(input logic [1:0] v, input logic [4:0] s0,
                             input logic [4:0] s1, input int stall,
                             input bit hold, input string name);
        int         w;
        logic [1:0] wb;
        logic [4:0] sw;
        req_valid = v;
        req_sel   = {s1, s0};
        rsp_ready = (stall > 0) ? 2'b00 : 2'b11;
        #1;
        w  = winner(v, ptr_m);
        wb = 2'(1 << w);
        sw = (w == 0) ? s0 : s1;
        total++;
        if (req_ready !== wb) begin
            bad++;
            $display("FAIL %s accept got=%b want=%b", name, req_ready, wb);
        end
        step();
        // ISSUE: the select must be the one sampled at accept.
        if (!hold) req_valid = v & ~wb;
        req_sel = 10'($urandom);
        #1;
        total++;
        if (addsel !== sw) begin
            bad++;
            $display("FAIL %s addsel got=%0d want=%0d", name, addsel, sw);
        end
        total++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL %s issue_hs got=%b/%b want=00/00", name, req_ready, rsp_valid);
        end
        step();
        total++;
        if (rsp_valid !== wb || rsp_data !== mux_byte(sw)) begin
            bad++;
            $display("FAIL %s rsp got=%b/%h want=%b/%h", name, rsp_valid, rsp_data, wb, mux_byte(sw));
        end
        for (int s = 0; s < stall; s++) begin
            rsp_ready = ~wb;
            step();
            total++;
            if (rsp_valid !== wb || rsp_data !== mux_byte(sw) || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL %s stall%0d got=%b/%h/%b want=%b/%h/00", name, s,
                         rsp_valid, rsp_data, req_ready, wb, mux_byte(sw));
            end
        end
        rsp_ready = (stall > 0) ? wb : 2'b11;
        step();
        ptr_m = (w + 1) % 2;
        total++;
        if (rsp_valid !== 2'b00 || addsel !== sw) begin
            bad++;
            $display("FAIL %s done got=%b/%0d want=00/%0d", name, rsp_valid, addsel, sw);
        end
    endtask

    task automatic test_single();
        serve_one(2'b01, 5'd5, 5'd0, 0, 1'b0, "single");
        // Back in IDLE with nothing requested: nothing accepted.
        req_valid = 2'b00;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL idle_none got=%b want=00", req_ready);
        end
        step();
    endtask

    task automatic test_priority();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        ptr_m = 0;
        serve_one(2'b11, 5'd3, 5'd31, 0, 1'b0, "prio_a");
        serve_one(2'b11, 5'd3, 5'd31, 0, 1'b0, "prio_b");
        serve_one(2'b11, 5'd3, 5'd31, 0, 1'b0, "prio_c");
    endtask

    task automatic test_backpressure();
        serve_one(2'b11, 5'd9, 5'd20, 5, 1'b0, "bp_a");
        serve_one(2'b11, 5'd9, 5'd20, 0, 1'b0, "bp_b");
    endtask

    task automatic test_reset_mid();
        // Move the pointer to 1, then start a request from requester 1.
        serve_one(2'b01, 5'd1, 5'd2, 0, 1'b0, "mid_pre");
        req_valid = 2'b10;
        req_sel   = {5'd7, 5'd0};
        rsp_ready = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL mid_accept got=%b want=10", req_ready);
        end
        step();
        rst       = 1'b1;
        req_valid = 2'b00;
        step();
        rst       = 1'b0;
        ptr_m     = 0;
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
            bad++;
            $display("FAIL mid_idle got=%b/%b want=01/00", req_ready, rsp_valid);
        end
        req_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (rsp_valid !== 2'b00) begin
                bad++;
                $display("FAIL mid_norsp%0d got=%b want=00", c, rsp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            logic [4:0] a;
            logic [4:0] b;
            a = (n == 0) ? 5'd0  : 5'($urandom);
            b = (n == 0) ? 5'd31 : 5'($urandom);
            serve_one(2'b11, a, b, 0, 1'b1, "b2b");
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [1:0] v;
            v = 2'($urandom);
            if (v == 2'b00) begin
                req_valid = 2'b00;
                #1;
                total++;
                if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
                    bad++;
                    $display("FAIL rnd_idle got=%b/%b want=00/00", req_ready, rsp_valid);
                end
                step();
            end else begin
                serve_one(v, 5'($urandom), 5'($urandom), int'($urandom_range(0, 2)),
                          1'($urandom), "rnd");
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_sel   = '0;
        rsp_ready = 2'b00;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
